nested_loop_counter: RTL and testbench

- Two-level (outer/inner) loop counter that sequences MLP layer evaluation: the inner index walks the inputs of a neuron and the outer index walks the neurons.
- Successor to the single saturating done-counter.
- Adds runtime-programmable bounds, a start/busy/done handshake, a stall enable, a synchronous abort, and a selectable saturate or auto-restart mode.
- Sits between the layer controller FSM and the weight/activation address generators.

---
 rtl/nested_loop_counter.sv | 107 ++++++++++
 tb/tb_nested_loop_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nested_loop_counter.sv
// nested_loop_counter
//   Two-level loop counter that sequences MLP layer evaluation. The inner index
//   walks the inputs of a neuron and the outer index walks the neurons. Bounds
//   are captured when a pass starts. Two completion modes are available:
//   AUTO_RESTART = 0 stops with a sticky done, and AUTO_RESTART = 1 wraps and
//   pulses done once per pass.
//
// Handshake: start is accepted only in IDLE or DONE. On the cycle after an
//   accepted start, busy goes high and the counters read (0,0). While busy, each
//   cycle with en = 1 advances the indices by one step. en = 0 stalls the
//   counters. clear aborts synchronously to IDLE and has the same effect as rst.
//   When clear and start arrive together, clear wins. When start and en arrive
//   together, the start takes effect and the counters do not advance.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, clear, en    pass start, synchronous abort, advance enable
//   inner_end/outer_end last indices (inclusive), sampled on accepted start
//   inner_cnt/outer_cnt current indices
//   inner_last, last    end-of-row / end-of-pass flags (only while busy)
//   busy, done          running flag, completion flag
//   state_dbg           FSM state for observation (0 IDLE, 1 RUN, 2 DONE)
module nested_loop_counter #(
  parameter int WIDTH        = 32,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] inner_end,
  input  logic [WIDTH-1:0] outer_end,
  output logic [WIDTH-1:0] inner_cnt,
  output logic [WIDTH-1:0] outer_cnt,
  output logic             inner_last,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] inner_end_q;
  logic [WIDTH-1:0] outer_end_q;

  // busy is a direct decode of the state register, so it is glitch-free.
  assign busy       = (state == S_RUN);
  assign inner_last = busy && (inner_cnt == inner_end_q);
  assign last       = inner_last && (outer_cnt == outer_end_q);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state       <= S_IDLE;
      inner_cnt   <= '0;
      outer_cnt   <= '0;
      inner_end_q <= '0;
      outer_end_q <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            inner_end_q <= inner_end;
            outer_end_q <= outer_end;
            inner_cnt   <= '0;
            outer_cnt   <= '0;
            done        <= 1'b0;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          // In wrap mode, done must drop on the next edge even if en stalls.
          // It is reasserted below only when the pass ends again.
          done <= 1'b0;
          if (en) begin
            if (!inner_last) begin
              inner_cnt <= inner_cnt + ONE;
            end else if (!last) begin
              inner_cnt <= '0;
              outer_cnt <= outer_cnt + ONE;
            end else if (AUTO_RESTART) begin
              inner_cnt <= '0;
              outer_cnt <= '0;
              done      <= 1'b1;
            end else begin
              // In stop mode the counters hold at their end values.
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nested_loop_counter.sv
// Bench for nested_loop_counter.
// dut_a is built with AUTO_RESTART = 0 and dut_b with AUTO_RESTART = 1.
// Both use 8-bit counters and share every input except start.
// Each driver step applies one cycle of inputs and queues the hand-computed
// outputs expected after that edge. The monitor pops and compares the queued
// values on the following falling edge.
module tb_nested_loop_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, clear, en, start_a, start_b;
  logic [W-1:0] inner_end, outer_end;

  logic [W-1:0] a_inner, a_outer, b_inner, b_outer;
  logic         a_il, a_last, a_busy, a_done, b_il, b_last, b_busy, b_done;
  logic [1:0]   a_state, b_state;

  // Expected vector layout: {sel, busy, done, last, inner_last, outer, inner}
  logic [4+2*W:0] exp_q[$];
  string          name_q[$];
  int             total = 0;
  int             bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  nested_loop_counter #(.WIDTH(W), .AUTO_RESTART(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .clear(clear), .en(en),
    .inner_end(inner_end), .outer_end(outer_end),
    .inner_cnt(a_inner), .outer_cnt(a_outer), .inner_last(a_il), .last(a_last),
    .busy(a_busy), .done(a_done), .state_dbg(a_state)
  );

  nested_loop_counter #(.WIDTH(W), .AUTO_RESTART(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .clear(clear), .en(en),
    .inner_end(inner_end), .outer_end(outer_end),
    .inner_cnt(b_inner), .outer_cnt(b_outer), .inner_last(b_il), .last(b_last),
    .busy(b_busy), .done(b_done), .state_dbg(b_state)
  );

  // ---------------- expected-value builders ----------------
  function automatic logic [4+2*W:0] mk(input logic sel, input logic busy,
      input logic done, input logic lst, input logic il,
      input int o, input int i);
    mk = {sel, busy, done, lst, il, W'(o), W'(i)};
  endfunction

  // Running, done low.
  function automatic logic [4+2*W:0] run_a(input int o, input int i,
      input logic il, input logic lst);
    run_a = mk(1'b0, 1'b1, 1'b0, lst, il, o, i);
  endfunction

  // Stopped in DONE: busy low, flags low, done high.
  function automatic logic [4+2*W:0] done_a(input int o, input int i);
    done_a = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, o, i);
  endfunction

  function automatic logic [4+2*W:0] idle_a();
    idle_a = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endfunction

  function automatic logic [4+2*W:0] run_b(input int o, input int i,
      input logic il, input logic lst, input logic dn);
    run_b = mk(1'b1, 1'b1, dn, lst, il, o, i);
  endfunction

  // ---------------- driver ----------------
  // Applies one cycle of inputs while the clock is low, queues the outputs
  // expected after the next rising edge, then waits for the falling edge.
  task automatic cyc(input string nm, input logic sel, input logic st,
      input logic cl, input logic e, input logic r, input logic [4+2*W:0] ex);
    rst     = r;
    clear   = cl;
    en      = e;
    start_a = st && !sel;
    start_b = st && sel;
    exp_q.push_back(ex);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4+2*W:0] ex, act;
      string          nm;
      ex = exp_q.pop_front();
      nm = name_q.pop_front();
      if (ex[4+2*W])
        act = {1'b1, b_busy, b_done, b_last, b_il, b_outer, b_inner};
      else
        act = {1'b0, a_busy, a_done, a_last, a_il, a_outer, a_inner};
      total++;
      if (act !== ex) begin
        bad++;
        $display("FAIL %s: got busy=%b done=%b last=%b il=%b o=%0d i=%0d, want busy=%b done=%b last=%b il=%b o=%0d i=%0d",
          nm, act[3+2*W], act[2+2*W], act[1+2*W], act[2*W], act[2*W-1:W], act[W-1:0],
          ex[3+2*W], ex[2+2*W], ex[1+2*W], ex[2*W], ex[2*W-1:W], ex[W-1:0]);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, got timeout, want finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4+2*W:0] tog[6];
    rst = 1'b1; clear = 1'b0; en = 1'b0; start_a = 1'b0; start_b = 1'b0;
    inner_end = '0; outer_end = '0;

    cyc("reset", 0, 0, 0, 0, 1, idle_a());
    cyc("idle_hold", 0, 0, 0, 1, 0, idle_a());

    // Pass of 3 x 2 with en held high.
    inner_end = 8'd2; outer_end = 8'd1;
    cyc("p1_start", 0, 1, 0, 1, 0, run_a(0, 0, 0, 0));
    cyc("p1_01", 0, 0, 0, 1, 0, run_a(0, 1, 0, 0));
    cyc("p1_02", 0, 0, 0, 1, 0, run_a(0, 2, 1, 0));
    cyc("p1_10", 0, 0, 0, 1, 0, run_a(1, 0, 0, 0));
    cyc("p1_11", 0, 0, 0, 1, 0, run_a(1, 1, 0, 0));
    cyc("p1_12_last", 0, 0, 0, 1, 0, run_a(1, 2, 1, 1));
    cyc("p1_done", 0, 0, 0, 1, 0, done_a(1, 2));
    for (int k = 0; k < 10; k++) cyc("p1_done_sticky", 0, 0, 0, 1, 0, done_a(1, 2));

    // Same pass restarted from DONE, with en alternating 1,0.
    tog[0] = run_a(0, 1, 0, 0);
    tog[1] = run_a(0, 2, 1, 0);
    tog[2] = run_a(1, 0, 0, 0);
    tog[3] = run_a(1, 1, 0, 0);
    tog[4] = run_a(1, 2, 1, 1);
    tog[5] = done_a(1, 2);
    cyc("p2_start", 0, 1, 0, 0, 0, run_a(0, 0, 0, 0));
    for (int k = 0; k < 6; k++) begin
      cyc("p2_en1", 0, 0, 0, 1, 0, tog[k]);
      cyc("p2_en0_hold", 0, 0, 0, 0, 0, tog[k]);
    end

    // Zero bounds, then a 4 x 1 pass whose start coincides with en.
    inner_end = 8'd0; outer_end = 8'd0;
    cyc("z_start", 0, 1, 0, 0, 0, run_a(0, 0, 1, 1));
    cyc("z_done", 0, 0, 0, 1, 0, done_a(0, 0));
    inner_end = 8'd3; outer_end = 8'd0;
    cyc("r_start_en", 0, 1, 0, 1, 0, run_a(0, 0, 0, 0));
    cyc("r_01", 0, 0, 0, 1, 0, run_a(0, 1, 0, 0));
    cyc("r_02", 0, 0, 0, 1, 0, run_a(0, 2, 0, 0));
    cyc("r_03_last", 0, 0, 0, 1, 0, run_a(0, 3, 1, 1));
    cyc("r_done", 0, 0, 0, 1, 0, done_a(0, 3));

    // A start during RUN carries new bounds and must be ignored.
    inner_end = 8'd2; outer_end = 8'd2;
    cyc("i_start", 0, 1, 0, 0, 0, run_a(0, 0, 0, 0));
    cyc("i_01", 0, 0, 0, 1, 0, run_a(0, 1, 0, 0));
    cyc("i_02", 0, 0, 0, 1, 0, run_a(0, 2, 1, 0));
    cyc("i_10", 0, 0, 0, 1, 0, run_a(1, 0, 0, 0));
    inner_end = 8'd1; outer_end = 8'd1;
    cyc("i_start_ignored", 0, 1, 0, 1, 0, run_a(1, 1, 0, 0));
    cyc("i_12", 0, 0, 0, 1, 0, run_a(1, 2, 1, 0));
    cyc("i_20", 0, 0, 0, 1, 0, run_a(2, 0, 0, 0));
    cyc("i_21", 0, 0, 0, 1, 0, run_a(2, 1, 0, 0));
    cyc("i_22_last", 0, 0, 0, 1, 0, run_a(2, 2, 1, 1));
    cyc("i_done", 0, 0, 0, 1, 0, done_a(2, 2));

    // Abort through clear, then through rst asserted together with start.
    inner_end = 8'd2; outer_end = 8'd2;
    cyc("c_start", 0, 1, 0, 0, 0, run_a(0, 0, 0, 0));
    cyc("c_01", 0, 0, 0, 1, 0, run_a(0, 1, 0, 0));
    cyc("c_clear", 0, 0, 1, 1, 0, idle_a());
    cyc("c_idle", 0, 0, 0, 1, 0, idle_a());
    cyc("c_clear_start", 0, 1, 1, 1, 0, idle_a());
    cyc("c_restart", 0, 1, 0, 0, 0, run_a(0, 0, 0, 0));
    cyc("c_01b", 0, 0, 0, 1, 0, run_a(0, 1, 0, 0));
    cyc("c_rst_start", 0, 1, 0, 1, 1, idle_a());
    cyc("c_idle2", 0, 0, 0, 1, 0, idle_a());

    // AUTO_RESTART = 1 with 2 x 2 bounds: done pulses once per 4 cycles.
    inner_end = 8'd1; outer_end = 8'd1;
    cyc("w_start", 1, 1, 0, 0, 0, run_b(0, 0, 0, 0, 0));
    for (int p = 0; p < 3; p++) begin
      cyc("w_01", 1, 0, 0, 1, 0, run_b(0, 1, 1, 0, 0));
      cyc("w_10", 1, 0, 0, 1, 0, run_b(1, 0, 0, 0, 0));
      cyc("w_11_last", 1, 0, 0, 1, 0, run_b(1, 1, 1, 1, 0));
      cyc("w_wrap_pulse", 1, 0, 0, 1, 0, run_b(0, 0, 0, 0, 1));
    end
    cyc("w_stall_pulse_drop", 1, 0, 0, 0, 0, run_b(0, 0, 0, 0, 0));
    cyc("w_start_in_run", 1, 1, 0, 1, 0, run_b(0, 1, 1, 0, 0));
    cyc("w_clear", 1, 0, 1, 1, 0, mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0));

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
